// File: rtl/fifo_pkg.sv
// Shared definitions for the synchronous FIFO and its write-side helpers.
package fifo_pkg;

  localparam int DATA_WIDTH_DEF = 32;
  localparam int ADDR_WIDTH_DEF = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  // Width needed to hold values 0..v-1; callers always pass v >= 2.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r = r + 1;
    return r;
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational round-robin search: first set bit of req at or after start, wrapping.
module rr_pick
  import fifo_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int PW    = clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [PW-1:0]    start,
  output logic [N_REQ-1:0] win,
  output logic             valid
);

  logic [PW:0]   sum;
  logic [PW-1:0] idx;

  always_comb begin
    win   = '0;
    valid = 1'b0;
    sum   = '0;
    idx   = '0;
    for (int i = 0; i < N_REQ; i++) begin
      // One extra bit keeps start+i from overflowing before the modulo fold.
      sum = {1'b0, start} + (PW+1)'(i);
      if (sum >= (PW+1)'(N_REQ)) sum = sum - (PW+1)'(N_REQ);
      idx = sum[PW-1:0];
      if (!valid && req[idx]) begin
        win[idx] = 1'b1;
        valid    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter sharing the FIFO write port between N_REQ producers.
module fifo_wr_arbiter
  import fifo_pkg::*;
#(
  parameter int N_REQ      = 4,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int MAX_BURST  = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [N_REQ-1:0]            req,
  input  logic [N_REQ*DATA_WIDTH-1:0] req_data,
  output logic [N_REQ-1:0]            ack,
  output logic [N_REQ-1:0]            gnt,
  input  logic                        fifo_full,
  output logic                        fifo_wr_en,
  output logic [DATA_WIDTH-1:0]       fifo_data_in,
  output logic                        busy
);

  localparam int PW = clog2(N_REQ);
  localparam int BW = clog2(MAX_BURST + 1);

  state_t                              state, state_n;
  logic [N_REQ-1:0]                    gnt_n;
  logic [PW-1:0]                       rr_ptr, rr_n;
  logic [BW-1:0]                       beat_cnt, cnt_n;
  logic [PW-1:0]                       g_idx, g_next, pick_start;
  logic [N_REQ-1:0]                    pick_win;
  logic                                pick_valid;
  logic                                beat, last_beat, release_g;
  logic [N_REQ-1:0][DATA_WIDTH-1:0]    lane_data;

  assign ack        = gnt & req & {N_REQ{~fifo_full}};
  assign fifo_wr_en = |ack;
  assign beat       = |ack;

  for (genvar i = 0; i < N_REQ; i++) begin : g_lane
    assign lane_data[i] = gnt[i] ? req_data[i*DATA_WIDTH +: DATA_WIDTH] : '0;
  end

  always_comb begin
    fifo_data_in = '0;
    for (int i = 0; i < N_REQ; i++) fifo_data_in = fifo_data_in | lane_data[i];
  end

  always_comb begin
    g_idx = '0;
    for (int i = 0; i < N_REQ; i++)
      if (gnt[i]) g_idx = PW'(i);
  end

  assign g_next = (g_idx == PW'(N_REQ-1)) ? '0 : g_idx + PW'(1);

  // Searching from g+1 leaves the current owner last, so a full-burst release
  // only re-grants it when nobody else is waiting.
  assign pick_start = (state == BURST) ? g_next : rr_ptr;

  rr_pick #(.N_REQ(N_REQ), .PW(PW)) u_pick (
    .req   (req),
    .start (pick_start),
    .win   (pick_win),
    .valid (pick_valid)
  );

  assign last_beat = beat && (beat_cnt == BW'(MAX_BURST-1));
  assign release_g = ~|(gnt & req) || last_beat;

  always_comb begin
    state_n = state;
    gnt_n   = gnt;
    rr_n    = rr_ptr;
    cnt_n   = beat_cnt;
    case (state)
      IDLE: begin
        if (pick_valid) begin
          gnt_n   = pick_win;
          cnt_n   = '0;
          state_n = BURST;
        end
      end
      BURST: begin
        if (release_g) begin
          rr_n  = g_next;
          cnt_n = '0;
          if (pick_valid) begin
            gnt_n = pick_win;
          end else begin
            gnt_n   = '0;
            state_n = IDLE;
          end
        end else if (beat) begin
          cnt_n = beat_cnt + BW'(1);
        end
      end
      default: begin
        gnt_n   = '0;
        state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      gnt      <= '0;
      rr_ptr   <= '0;
      beat_cnt <= '0;
      busy     <= 1'b0;
    end else begin
      state    <= state_n;
      gnt      <= gnt_n;
      rr_ptr   <= rr_n;
      beat_cnt <= cnt_n;
      busy     <= (state_n == BURST);
    end
  end

endmodule
